rsa_stream_sequencer: RTL and testbench

- Byte-stream front-end and sequencer for the 256-bit RSA modular-exponentiation core.
- Loads modulus n and exponent d once, then processes ciphertext blocks continuously: 32 bytes in, start core, wait for completion, 31 plaintext bytes out.
- Sits between the host byte link (UART/bus bridge) and the core.
- The top plaintext byte is dropped; plaintext is 248 bits.

---
 rtl/rsa_stream_sequencer.sv | 158 +++++++++++++++
 tb/tb_rsa_stream_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_stream_sequencer.sv
// Byte-stream front end and sequencer for the 256-bit RSA modexp core: loads n and d, then loops ciphertext in / plaintext out.
// Optional core watchdog enabled by defining RSA_SEQ_WDOG_EN.
module rsa_stream_sequencer #(
    parameter int BYTES_IN    = 32,
    parameter int BYTES_OUT   = 31,
    parameter int WDOG_CYCLES = 500000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_rx_ready,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    input  logic         i_key_reload,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished,
    output logic         o_busy,
    output logic [15:0]  o_block_cnt,
    output logic         o_err
);
    // state   | meaning
    // LOAD_N  | shifting in modulus bytes
    // LOAD_D  | shifting in exponent bytes
    // LOAD_A  | shifting in ciphertext bytes; key reload allowed at byte 0
    // START   | one-cycle core start pulse
    // WAIT    | waiting for core completion
    // SEND    | shifting plaintext bytes out
    typedef enum logic [2:0] {
        S_LOAD_N, S_LOAD_D, S_LOAD_A, S_START, S_WAIT, S_SEND
    } state_t;

    localparam logic [4:0] LAST_IN  = 5'(BYTES_IN - 1);
    localparam logic [4:0] LAST_OUT = 5'(BYTES_OUT - 1);

    state_t         state, state_nxt;
    logic [4:0]     byte_cnt;
    logic [255:0]   n_reg, d_reg, a_reg;
    logic [247:0]   out_reg;
    logic [15:0]    block_cnt;
    logic           rx_ready, tx_valid, core_start;
    logic           rx_fire, tx_fire, wdog_expire;
    logic           unused_result;

    assign unused_result = ^i_core_result[255:248];

    always_comb begin
        state_nxt  = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        core_start = 1'b0;
        case (state)
            S_LOAD_N: begin
                rx_ready = 1'b1;
                if (i_rx_valid && byte_cnt == LAST_IN) state_nxt = S_LOAD_D;
            end
            S_LOAD_D: begin
                rx_ready = 1'b1;
                if (i_rx_valid && byte_cnt == LAST_IN) state_nxt = S_LOAD_A;
            end
            S_LOAD_A: begin
                // reload only at a block boundary so no ciphertext is half-consumed
                if (i_key_reload && byte_cnt == 5'd0) begin
                    state_nxt = S_LOAD_N;
                end else begin
                    rx_ready = 1'b1;
                    if (i_rx_valid && byte_cnt == LAST_IN) state_nxt = S_START;
                end
            end
            S_START: begin
                core_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_finished)  state_nxt = S_SEND;
                else if (wdog_expire) state_nxt = S_LOAD_A;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (i_tx_ready && byte_cnt == LAST_OUT) state_nxt = S_LOAD_A;
            end
            default: state_nxt = S_LOAD_N;
        endcase
    end

    assign rx_fire = i_rx_valid & rx_ready;
    assign tx_fire = tx_valid & i_tx_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_LOAD_N;
            byte_cnt  <= 5'd0;
            n_reg     <= '0;
            d_reg     <= '0;
            a_reg     <= '0;
            out_reg   <= '0;
            block_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            // one counter serves both directions; it always sits at 0 between phases
            if (rx_fire) byte_cnt <= (byte_cnt == LAST_IN) ? 5'd0 : byte_cnt + 5'd1;
            else if (tx_fire) byte_cnt <= (byte_cnt == LAST_OUT) ? 5'd0 : byte_cnt + 5'd1;
            if (rx_fire) begin
                case (state)
                    S_LOAD_N: n_reg <= {n_reg[247:0], i_rx_data};
                    S_LOAD_D: d_reg <= {d_reg[247:0], i_rx_data};
                    S_LOAD_A: a_reg <= {a_reg[247:0], i_rx_data};
                    default: ;
                endcase
            end
            if (state == S_WAIT && i_core_finished) out_reg <= i_core_result[247:0];
            else if (tx_fire) out_reg <= {out_reg[239:0], 8'h00};
            if (tx_fire && byte_cnt == LAST_OUT) block_cnt <= block_cnt + 16'd1;
        end
    end

`ifdef RSA_SEQ_WDOG_EN
    localparam logic [19:0] WDOG_LAST = 20'(WDOG_CYCLES - 1);
    logic [19:0] wdog_cnt;
    logic        err;

    assign wdog_expire = (state == S_WAIT) && !i_core_finished && (wdog_cnt == WDOG_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog_cnt <= 20'd0;
            err      <= 1'b0;
        end else begin
            if (state == S_START)     wdog_cnt <= 20'd0;
            else if (state == S_WAIT) wdog_cnt <= wdog_cnt + 20'd1;
            if (wdog_expire) err <= 1'b1;
        end
    end

    assign o_err = err;
`else
    logic [19:0] unused_wdog;
    assign unused_wdog = 20'(WDOG_CYCLES);
    assign wdog_expire = 1'b0;
    assign o_err       = 1'b0;
`endif

    assign o_rx_ready   = rx_ready;
    assign o_tx_valid   = tx_valid;
    assign o_tx_data    = out_reg[247:240];
    assign o_core_start = core_start;
    assign o_core_a     = a_reg;
    assign o_core_d     = d_reg;
    assign o_core_n     = n_reg;
    assign o_block_cnt  = block_cnt;
    assign o_busy       = (state == S_START) || (state == S_WAIT) || (state == S_SEND);

endmodule

// File: tb/tb_rsa_stream_sequencer.sv
// Directed bench for rsa_stream_sequencer (default build, watchdog off).
module tb_rsa_stream_sequencer;
    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [7:0]   i_rx_data = 8'h00;
    logic         i_rx_valid = 1'b0;
    logic         o_rx_ready;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready = 1'b0;
    logic         i_key_reload = 1'b0;
    logic         o_core_start;
    logic [255:0] o_core_a, o_core_d, o_core_n;
    logic [255:0] i_core_result = '0;
    logic         i_core_finished = 1'b0;
    logic         o_busy;
    logic [15:0]  o_block_cnt;
    logic         o_err;

    rsa_stream_sequencer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .i_key_reload(i_key_reload), .o_core_start(o_core_start),
        .o_core_a(o_core_a), .o_core_d(o_core_d), .o_core_n(o_core_n),
        .i_core_result(i_core_result), .i_core_finished(i_core_finished),
        .o_busy(o_busy), .o_block_cnt(o_block_cnt), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [255:0] N1 = 256'hCA3586E7_5B21F04D_9E6A17C3_44D80B92_71FE3A65_0C9D28B4_E36F5A17_029CF831;
    localparam logic [255:0] D1 = 256'hB6ACE0B1_3F7D9245_8A1C66E0_D25B4F19_07E3A8C2_5D91F6B3_2A48E07C_BCF46BD9;
    localparam logic [255:0] N2 = 256'h9F0E1D2C_3B4A5968_778695A4_B3C2D1E0_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F1;
    localparam logic [255:0] D2 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_1357_9BDF_2468_ACE0_0F0F_F0F0_5A5A_A5A5;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;

    always @(posedge i_clk) if (o_core_start) start_cnt <= start_cnt + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [247:0] seq_bytes(input logic [7:0] base);
        logic [247:0] r;
        r = '0;
        for (int i = 0; i < 31; i++) r[247-8*i -: 8] = base + 8'(i);
        return r;
    endfunction

    // called at a negedge; returns just after the posedge that transferred the byte
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge i_clk);
            i_rx_valid = 1'b0;
        end
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        #1;
        t = 0;
        while (!o_rx_ready && t < 50) begin
            @(negedge i_clk);
            #1;
            t++;
        end
        if (t >= 50) chk("rx_timeout", 256'd0, 256'd1);
        @(posedge i_clk);
    endtask

    task automatic send_vec(input logic [255:0] v, input int gap);
        for (int i = 0; i < 32; i++) send_byte(v[255-8*i -: 8], gap);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    // called at the negedge where o_tx_valid first goes high
    task automatic receive(input logic [247:0] res, input bit bp);
        int k, cyc;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        k = 0;
        cyc = 0;
        while (k < 31 && cyc < 400) begin
            i_tx_ready = bp ? pat[cyc % 4] : 1'b1;
            #1;
            chk("tx_valid", 256'(o_tx_valid), 256'd1);
            chk(i_tx_ready ? "tx_data" : "tx_hold", 256'(o_tx_data), 256'(res[247-8*k -: 8]));
            if (i_tx_ready) k++;
            @(negedge i_clk);
            cyc++;
        end
        i_tx_ready = 1'b0;
        chk("tx_count", 256'(k), 256'd31);
        #1;
        chk("tx_valid_end", 256'(o_tx_valid), 256'd0);
    endtask

    task automatic run_block(input logic [255:0] a, input logic [7:0] top,
                             input logic [247:0] res, input int gap, input bit bp,
                             input logic [15:0] exp_blocks);
        int s0;
        s0 = start_cnt;
        send_vec(a, gap);
        #1;
        chk("start_lat", 256'(o_core_start), 256'd1);
        chk("core_a", o_core_a, a);
        chk("busy", 256'(o_busy), 256'd1);
        repeat (100) @(negedge i_clk);
        #1;
        chk("wait_no_tx", 256'(o_tx_valid), 256'd0);
        chk("wait_rx_ready", 256'(o_rx_ready), 256'd0);
        i_core_result   = {top, res};
        i_core_finished = 1'b1;
        @(negedge i_clk);
        i_core_finished = 1'b0;
        receive(res, bp);
        chk("block_cnt", 256'(o_block_cnt), 256'(exp_blocks));
        chk("start_pulses", 256'(start_cnt - s0), 256'd1);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_rx_ready", 256'(o_rx_ready), 256'd1);
        chk("rst_tx_valid", 256'(o_tx_valid), 256'd0);
        chk("rst_core_n", o_core_n, 256'd0);
        chk("rst_block_cnt", 256'(o_block_cnt), 256'd0);
        chk("rst_busy", 256'(o_busy), 256'd0);
        chk("rst_err", 256'(o_err), 256'd0);
        i_rst_n = 1'b1;

        send_vec(N1, 0);
        send_vec(D1, 0);
        chk("core_n", o_core_n, N1);
        chk("core_d", o_core_d, D1);
        run_block(256'h1122334455667788_99AABBCCDDEEFF00_0102030405060708_F0E0D0C0B0A09080,
                  8'h00, seq_bytes(8'h01), 0, 1'b0, 16'd1);

        run_block(256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0,
                  8'hA5, seq_bytes(8'h80), 1, 1'b1, 16'd2);
        for (int b = 0; b < 3; b++)
            run_block({8'(b), 248'h5555}, 8'hFF, seq_bytes(8'(8'h20 + 8'(b) * 8'h40)), 0, 1'b0,
                      16'(3 + b));
        chk("keys_n_kept", o_core_n, N1);
        chk("keys_d_kept", o_core_d, D1);
        chk("block_cnt_5", 256'(o_block_cnt), 256'd5);

        // stray completion outside WAIT must be ignored
        i_core_result   = {8'h00, seq_bytes(8'h10)};
        i_core_finished = 1'b1;
        @(negedge i_clk);
        i_core_finished = 1'b0;
        #1;
        chk("stray_finish", 256'(o_tx_valid), 256'd0);

        i_key_reload = 1'b1;
        i_rx_valid   = 1'b1;
        i_rx_data    = 8'hAA;
        #1;
        chk("reload_ready", 256'(o_rx_ready), 256'd0);
        @(negedge i_clk);
        i_key_reload = 1'b0;
        i_rx_valid   = 1'b0;
        send_vec(N2, 0);
        send_vec(D2, 0);
        chk("reload_n", o_core_n, N2);
        chk("reload_d", o_core_d, D2);
        run_block(256'h77, 8'h00, seq_bytes(8'hC0), 0, 1'b0, 16'd6);

        send_vec(256'h1234, 0);
        repeat (10) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_core_n", o_core_n, 256'd0);
        chk("mid_rst_core_a", o_core_a, 256'd0);
        chk("mid_rst_blocks", 256'(o_block_cnt), 256'd0);
        chk("mid_rst_busy", 256'(o_busy), 256'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        i_core_finished = 1'b1;
        @(negedge i_clk);
        i_core_finished = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("post_rst_no_tx", 256'(o_tx_valid), 256'd0);
        chk("post_rst_ready", 256'(o_rx_ready), 256'd1);
        chk("post_rst_core_d", o_core_d, 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
